// File: rtl/pc_exception_unit_pkg.sv
// Shared types and constants for the PC / exception unit and its helpers.
//   - exc_state_e   : exception sequencer states
//   - cause_e       : cause register encodings
//   - branch_type_e : conditional-branch encodings
//   - exc_sel_t     : prioritised exception selection payload
package pc_exception_unit_pkg;

  localparam int unsigned XLEN     = 32;
  localparam int unsigned BYTE_W   = 8;
  localparam int unsigned BYTE_PAD = XLEN - BYTE_W;

  // Default vector-table byte addresses for each handler.
  localparam logic [XLEN-1:0] DEF_VEC_OPCODE = 32'd255;
  localparam logic [XLEN-1:0] DEF_VEC_OVF    = 32'd254;
  localparam logic [XLEN-1:0] DEF_VEC_DIV0   = 32'd253;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_LOAD = 2'b10
  } exc_state_e;

  typedef enum logic [1:0] {
    CAUSE_NONE   = 2'b00,
    CAUSE_OPCODE = 2'b01,
    CAUSE_OVF    = 2'b10,
    CAUSE_DIV0   = 2'b11
  } cause_e;

  typedef enum logic [1:0] {
    BR_BEQ = 2'b00,
    BR_BNE = 2'b01,
    BR_BGT = 2'b10,
    BR_BLE = 2'b11
  } branch_type_e;

  typedef struct packed {
    logic            valid;
    cause_e          code;
    logic [XLEN-1:0] vec;
  } exc_sel_t;

  // Fixed priority opcode > ovf > div0; lower-priority requests are dropped.
  function automatic exc_sel_t exc_select(
    input logic            opcode,
    input logic            ovf,
    input logic            div0,
    input logic [XLEN-1:0] vec_opcode,
    input logic [XLEN-1:0] vec_ovf,
    input logic [XLEN-1:0] vec_div0
  );
    exc_sel_t sel;
    sel.valid = opcode | ovf | div0;
    sel.code  = CAUSE_NONE;
    sel.vec   = '0;
    if (opcode) begin
      sel.code = CAUSE_OPCODE;
      sel.vec  = vec_opcode;
    end else if (ovf) begin
      sel.code = CAUSE_OVF;
      sel.vec  = vec_ovf;
    end else if (div0) begin
      sel.code = CAUSE_DIV0;
      sel.vec  = vec_div0;
    end
    return sel;
  endfunction

endpackage

// File: rtl/pc_exception_unit_branch_cond_eval.sv
// Branch condition evaluator (combinational, shared with the control unit).
//   branch_type : 00 beq, 01 bne, 10 bgt, 11 ble
//   alu_zero    : ALU zero flag
//   alu_gt      : ALU greater-than flag
//   take        : branch condition satisfied
module branch_cond_eval
  import pc_exception_unit_pkg::*;
(
  input  logic [1:0] branch_type,
  input  logic       alu_zero,
  input  logic       alu_gt,
  output logic       take
);

  // Condition lookup per branch encoding.
  always_comb begin
    take = 1'b0;
    case (branch_type)
      BR_BEQ:  take = alu_zero;
      BR_BNE:  take = ~alu_zero;
      BR_BGT:  take = alu_gt;
      BR_BLE:  take = ~alu_gt;
      default: take = 1'b0;
    endcase
  end

endmodule

// File: rtl/pc_exception_unit.sv
// Architectural PC register, branch-qualified PC update, EPC capture and the
// exception entry sequence (vector byte fetch, then PC load with the handler).
//   clk, reset    : clock, async active-low reset
//   pc_next       : selected next-PC value
//   pc_write      : unconditional PC load
//   pc_write_cond : PC load qualified by branch_type / ALU flags
//   branch_type, alu_zero, alu_gt : branch condition inputs
//   exc_opcode, exc_ovf, exc_div0 : exception pulses from control
//   mem_rdata, mem_valid          : vector byte returned by the memory port
//   pc, epc, cause                : architectural state
//   exc_mem_req, exc_mem_addr     : vector-table read request
//   exc_busy                      : stall to control during the sequence
module pc_exception_unit
  import pc_exception_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] EPC_OFFSET = 32'd4,
  parameter logic [31:0] VEC_OPCODE = DEF_VEC_OPCODE,
  parameter logic [31:0] VEC_OVF    = DEF_VEC_OVF,
  parameter logic [31:0] VEC_DIV0   = DEF_VEC_DIV0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [XLEN-1:0]   pc_next,
  input  logic              pc_write,
  input  logic              pc_write_cond,
  input  logic [1:0]        branch_type,
  input  logic              alu_zero,
  input  logic              alu_gt,
  input  logic              exc_opcode,
  input  logic              exc_ovf,
  input  logic              exc_div0,
  input  logic [BYTE_W-1:0] mem_rdata,
  input  logic              mem_valid,
  output logic [XLEN-1:0]   pc,
  output logic [XLEN-1:0]   epc,
  output logic [1:0]        cause,
  output logic              exc_mem_req,
  output logic [XLEN-1:0]   exc_mem_addr,
  output logic              exc_busy
);

  exc_state_e        state_q, state_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic [XLEN-1:0]   epc_q, epc_d;
  cause_e            cause_q, cause_d;
  logic              req_q, req_d;
  logic [XLEN-1:0]   addr_q, addr_d;
  logic              busy_q, busy_d;
  logic [BYTE_W-1:0] vec_byte_q, vec_byte_d;

  logic     take_c;
  exc_sel_t sel_c;

  branch_cond_eval u_branch_cond_eval (
    .branch_type (branch_type),
    .alu_zero    (alu_zero),
    .alu_gt      (alu_gt),
    .take        (take_c)
  );

  assign sel_c = exc_select(exc_opcode, exc_ovf, exc_div0,
                            VEC_OPCODE, VEC_OVF, VEC_DIV0);

  // Next-state and next-output logic; every register holds by default.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    epc_d      = epc_q;
    cause_d    = cause_q;
    req_d      = req_q;
    addr_d     = addr_q;
    busy_d     = busy_q;
    vec_byte_d = vec_byte_q;

    case (state_q)
      ST_IDLE: begin
        // An exception wins over any PC write presented in the same cycle.
        if (sel_c.valid) begin
          epc_d   = pc_q - EPC_OFFSET;
          cause_d = sel_c.code;
          addr_d  = sel_c.vec;
          req_d   = 1'b1;
          busy_d  = 1'b1;
          state_d = ST_REQ;
        end else if (pc_write || (pc_write_cond && take_c)) begin
          pc_d = pc_next;
        end
      end

      ST_REQ: begin
        // Wait as long as the arbiter needs; request drops with the byte.
        if (mem_valid) begin
          vec_byte_d = mem_rdata;
          req_d      = 1'b0;
          state_d    = ST_LOAD;
        end
      end

      ST_LOAD: begin
        pc_d    = {{BYTE_PAD{1'b0}}, vec_byte_q};
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end

      default: begin
        req_d   = 1'b0;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      pc_q       <= RESET_PC;
      epc_q      <= '0;
      cause_q    <= CAUSE_NONE;
      req_q      <= 1'b0;
      addr_q     <= '0;
      busy_q     <= 1'b0;
      vec_byte_q <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      epc_q      <= epc_d;
      cause_q    <= cause_d;
      req_q      <= req_d;
      addr_q     <= addr_d;
      busy_q     <= busy_d;
      vec_byte_q <= vec_byte_d;
    end
  end

  assign pc           = pc_q;
  assign epc          = epc_q;
  assign cause        = cause_q;
  assign exc_mem_req  = req_q;
  assign exc_mem_addr = addr_q;
  assign exc_busy     = busy_q;

endmodule

// File: tb/tb_pc_exception_unit.sv
// Self-checking bench for pc_exception_unit: branch-condition vector table,
// hand-written exception sequences, and a randomized run against a model.
module tb_pc_exception_unit;

  logic        clk;
  logic        reset;
  logic [31:0] pc_next;
  logic        pc_write;
  logic        pc_write_cond;
  logic [1:0]  branch_type;
  logic        alu_zero;
  logic        alu_gt;
  logic        exc_opcode;
  logic        exc_ovf;
  logic        exc_div0;
  logic [7:0]  mem_rdata;
  logic        mem_valid;
  logic [31:0] pc;
  logic [31:0] epc;
  logic [1:0]  cause;
  logic        exc_mem_req;
  logic [31:0] exc_mem_addr;
  logic        exc_busy;

  int total = 0;
  int bad   = 0;

  pc_exception_unit dut (
    .clk           (clk),
    .reset         (reset),
    .pc_next       (pc_next),
    .pc_write      (pc_write),
    .pc_write_cond (pc_write_cond),
    .branch_type   (branch_type),
    .alu_zero      (alu_zero),
    .alu_gt        (alu_gt),
    .exc_opcode    (exc_opcode),
    .exc_ovf       (exc_ovf),
    .exc_div0      (exc_div0),
    .mem_rdata     (mem_rdata),
    .mem_valid     (mem_valid),
    .pc            (pc),
    .epc           (epc),
    .cause         (cause),
    .exc_mem_req   (exc_mem_req),
    .exc_mem_addr  (exc_mem_addr),
    .exc_busy      (exc_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        pw;
    logic        pwc;
    logic [1:0]  bt;
    logic        z;
    logic        gt;
    logic [31:0] nxt;
    logic [31:0] exp_pc;
  } vec_t;

  vec_t tbl[11];

  // Reference model state (exception flow described as "waiting for the
  // vector byte" followed by "one cycle to install the handler").
  logic [31:0] m_pc, m_epc, m_addr;
  logic [1:0]  m_cause;
  bit          m_waiting, m_installing;
  logic [7:0]  m_handler;
  logic [31:0] vec_of_code[4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    pc_next = '0; pc_write = 0; pc_write_cond = 0; branch_type = '0;
    alu_zero = 0; alu_gt = 0; exc_opcode = 0; exc_ovf = 0; exc_div0 = 0;
    mem_rdata = '0; mem_valid = 0;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_pc"},   pc, 32'h0);
    check({tag, "_epc"},  epc, 32'h0);
    check({tag, "_cause"}, 32'(cause), 32'h0);
    check({tag, "_req"},  32'(exc_mem_req), 32'h0);
    check({tag, "_addr"}, exc_mem_addr, 32'h0);
    check({tag, "_busy"}, 32'(exc_busy), 32'h0);
  endtask

  task automatic apply_reset();
    idle_inputs();
    @(posedge clk);
    #2 reset = 1'b0;
    step();
    #1 reset = 1'b1;
    #1;
  endtask

  // Model advance for one clock edge, using the inputs currently applied.
  task automatic model_edge();
    logic [3:0] conds;
    logic [1:0] code;
    conds = {~alu_gt, alu_gt, ~alu_zero, alu_zero};
    if (m_installing) begin
      m_pc = {24'h0, m_handler};
      m_installing = 0;
    end else if (m_waiting) begin
      if (mem_valid) begin
        m_handler    = mem_rdata;
        m_waiting    = 0;
        m_installing = 1;
      end
    end else if (exc_opcode || exc_ovf || exc_div0) begin
      code      = exc_opcode ? 2'd1 : (exc_ovf ? 2'd2 : 2'd3);
      m_cause   = code;
      m_addr    = vec_of_code[code];
      m_epc     = m_pc - 32'd4;
      m_waiting = 1;
    end else if (pc_write || (pc_write_cond && conds[branch_type])) begin
      m_pc = pc_next;
    end
  endtask

  initial begin
    int busy_cnt;
    int req_cnt;

    vec_of_code[0] = 32'd0;
    vec_of_code[1] = 32'd255;
    vec_of_code[2] = 32'd254;
    vec_of_code[3] = 32'd253;

    //            pw  pwc bt     z  gt  nxt           exp_pc
    tbl[0]  = '{1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 32'h40,  32'h40};
    tbl[1]  = '{1'b0, 1'b1, 2'b01, 1'b1, 1'b0, 32'h80,  32'h40};
    tbl[2]  = '{1'b0, 1'b1, 2'b01, 1'b0, 1'b0, 32'h80,  32'h80};
    tbl[3]  = '{1'b0, 1'b1, 2'b00, 1'b1, 1'b0, 32'h90,  32'h90};
    tbl[4]  = '{1'b0, 1'b1, 2'b00, 1'b0, 1'b1, 32'hA0,  32'h90};
    tbl[5]  = '{1'b0, 1'b1, 2'b10, 1'b0, 1'b1, 32'hB0,  32'hB0};
    tbl[6]  = '{1'b0, 1'b1, 2'b10, 1'b1, 1'b0, 32'hC0,  32'hB0};
    tbl[7]  = '{1'b0, 1'b1, 2'b11, 1'b0, 1'b0, 32'hD0,  32'hD0};
    tbl[8]  = '{1'b0, 1'b1, 2'b11, 1'b0, 1'b1, 32'hE0,  32'hD0};
    tbl[9]  = '{1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 32'hF0,  32'hD0};
    tbl[10] = '{1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 32'h104, 32'h104};

    idle_inputs();
    reset = 1'b0;
    repeat (2) step();
    check_reset_values("rst");
    reset = 1'b1;

    // Branch condition / PC write vectors.
    foreach (tbl[i]) begin
      pc_write = tbl[i].pw; pc_write_cond = tbl[i].pwc; branch_type = tbl[i].bt;
      alu_zero = tbl[i].z;  alu_gt = tbl[i].gt;         pc_next = tbl[i].nxt;
      step();
      check($sformatf("vec%0d_pc", i), pc, tbl[i].exp_pc);
    end
    idle_inputs();
    check("vec_epc", epc, 32'h0);
    check("vec_cause", 32'(cause), 32'h0);

    // Overflow at pc=0x104, vector byte arrives in the second REQ cycle.
    busy_cnt = 0;
    exc_ovf = 1; pc_write = 1; pc_next = 32'h5555;
    step();
    idle_inputs();
    if (exc_busy) busy_cnt++;
    check("ovf_epc", epc, 32'h100);
    check("ovf_cause", 32'(cause), 32'h2);
    check("ovf_addr", exc_mem_addr, 32'd254);
    check("ovf_req", 32'(exc_mem_req), 32'h1);
    check("ovf_pc_held", pc, 32'h104);
    step();
    if (exc_busy) busy_cnt++;
    check("ovf_req_wait", 32'(exc_mem_req), 32'h1);
    mem_valid = 1; mem_rdata = 8'h3C;
    step();
    idle_inputs();
    if (exc_busy) busy_cnt++;
    check("ovf_req_drop", 32'(exc_mem_req), 32'h0);
    check("ovf_pc_preload", pc, 32'h104);
    step();
    if (exc_busy) busy_cnt++;
    check("ovf_pc_handler", pc, 32'h3C);
    check("ovf_busy_cycles", 32'(busy_cnt), 32'd3);

    // Simultaneous opcode+div0; a nested ovf during REQ is dropped.
    exc_opcode = 1; exc_div0 = 1;
    step();
    idle_inputs();
    check("prio_cause", 32'(cause), 32'h1);
    check("prio_addr", exc_mem_addr, 32'd255);
    check("prio_epc", epc, 32'h38);
    exc_ovf = 1;
    step();
    exc_ovf = 0;
    check("nest_cause", 32'(cause), 32'h1);
    check("nest_epc", epc, 32'h38);
    mem_valid = 1; mem_rdata = 8'h11;
    step();
    idle_inputs();
    step();
    check("prio_pc_handler", pc, 32'h11);

    // Div0 with the vector byte delayed five cycles; PC writes ignored.
    exc_div0 = 1;
    step();
    idle_inputs();
    check("dly_cause", 32'(cause), 32'h3);
    check("dly_epc", epc, 32'hD);
    check("dly_addr", exc_mem_addr, 32'd253);
    req_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (!exc_mem_req) break;
      req_cnt++;
      pc_write = 1; pc_next = 32'hDEAD;
      mem_valid = (i == 5); mem_rdata = 8'h77;
      step();
    end
    mem_valid = 0;
    check("dly_req_cycles", 32'(req_cnt), 32'd6);
    check("dly_pc_wait", pc, 32'h11);
    step();
    check("dly_pc_handler", pc, 32'h77);
    pc_write = 0;
    step();
    check("dly_busy_done", 32'(exc_busy), 32'h0);
    check("dly_pc_idle", pc, 32'h77);

    // Reset asserted mid-REQ.
    exc_ovf = 1;
    step();
    idle_inputs();
    check("mid_req", 32'(exc_mem_req), 32'h1);
    #2 reset = 1'b0;
    #1;
    check_reset_values("midrst");
    step();
    #1 reset = 1'b1;
    mem_valid = 1; mem_rdata = 8'hAA;
    step();
    mem_valid = 0;
    check("post_rst_pc", pc, 32'h0);
    check("post_rst_busy", 32'(exc_busy), 32'h0);
    pc_write = 1; pc_next = 32'h44;
    step();
    pc_write = 0;
    check("post_rst_idle_write", pc, 32'h44);

    // Randomized run against the reference model.
    apply_reset();
    m_pc = 32'h0; m_epc = 32'h0; m_addr = 32'h0; m_cause = 2'd0;
    m_waiting = 0; m_installing = 0; m_handler = 8'h0;
    for (int n = 0; n < 3000; n++) begin
      pc_next       = {$urandom_range(0, 32'h3FFF), 2'b00};
      pc_write      = ($urandom_range(0, 3) == 0);
      pc_write_cond = ($urandom_range(0, 1) == 0);
      branch_type   = 2'($urandom_range(0, 3));
      alu_zero      = 1'($urandom_range(0, 1));
      alu_gt        = 1'($urandom_range(0, 1));
      exc_opcode    = ($urandom_range(0, 15) == 0);
      exc_ovf       = ($urandom_range(0, 11) == 0);
      exc_div0      = ($urandom_range(0, 11) == 0);
      mem_valid     = ($urandom_range(0, 2) == 0);
      mem_rdata     = 8'($urandom_range(0, 255));
      model_edge();
      step();
      check("rnd_pc", pc, m_pc);
      check("rnd_epc", epc, m_epc);
      check("rnd_cause", 32'(cause), 32'(m_cause));
      check("rnd_addr", exc_mem_addr, m_addr);
      check("rnd_req", 32'(exc_mem_req), 32'(m_waiting));
      check("rnd_busy", 32'(exc_busy), 32'(m_waiting || m_installing));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
